// File: rtl/pc_seq_if.sv
// Command handshake and byte-read bus between decode, the PC sequencer and the bus interface.
interface pc_seq_if;
  logic        cmd_valid;
  logic [2:0]  cmd_op;
  logic [7:0]  cmd_off;
  logic        cmd_ready;
  logic        bus_rd;
  logic [15:0] bus_addr;
  logic [7:0]  bus_data;

  // Issuer and memory side.
  modport master (
    output cmd_valid, cmd_op, cmd_off, bus_data,
    input  cmd_ready, bus_rd, bus_addr
  );

  // Sequencer side.
  modport slave (
    input  cmd_valid, cmd_op, cmd_off, bus_data,
    output cmd_ready, bus_rd, bus_addr
  );
endinterface

// File: rtl/pc_seq.sv
// 6502 program-counter sequencer: increment, relative branch with page-cross fix-up,
// two-byte absolute/vector loads and edge-triggered NMI.
module pc_seq #(
  parameter logic [15:0] RST_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  pc_seq_if.slave     bus,
  input  logic        nmi,
  output logic [15:0] pc,
  output logic        done
);

  typedef enum logic [2:0] {StIdle, StFix, StRdLo, StRdHi, StWaitHi} state_e;

  localparam logic [2:0] OpInc    = 3'd0;
  localparam logic [2:0] OpBranch = 3'd1;
  localparam logic [2:0] OpJmp    = 3'd2;
  localparam logic [2:0] OpVecRst = 3'd3;
  localparam logic [2:0] OpVecIrq = 3'd4;

  state_e      state_q;
  logic [15:0] pc_q;
  logic [15:0] bus_addr_q;
  logic        bus_rd_q;
  logic        done_q;
  logic [7:0]  lo_q;
  logic [7:0]  tgt_hi_q;
  logic        nmi_prev_q;
  logic        nmi_pend_q;

  logic        nmi_edge;
  logic [15:0] target;

  assign nmi_edge      = nmi && !nmi_prev_q;
  assign target        = pc_q + {{8{bus.cmd_off[7]}}, bus.cmd_off};
  assign bus.cmd_ready = (state_q == StIdle) && !nmi_pend_q && !rst;
  assign bus.bus_rd    = bus_rd_q;
  assign bus.bus_addr  = bus_addr_q;
  assign pc            = pc_q;
  assign done          = done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      pc_q       <= RST_PC;
      bus_addr_q <= 16'h0000;
      bus_rd_q   <= 1'b0;
      done_q     <= 1'b0;
      lo_q       <= 8'h00;
      tgt_hi_q   <= 8'h00;
      nmi_prev_q <= 1'b0;
      nmi_pend_q <= 1'b0;
    end else begin
      nmi_prev_q <= nmi;
      done_q     <= 1'b0;
      if (nmi_edge) nmi_pend_q <= 1'b1;

      case (state_q)
        StIdle: begin
          if (nmi_pend_q) begin
            // A fresh edge in this very cycle queues another NMI behind this one.
            nmi_pend_q <= nmi_edge;
            bus_rd_q   <= 1'b1;
            bus_addr_q <= 16'hFFFA;
            state_q    <= StRdLo;
          end else if (bus.cmd_valid) begin
            case (bus.cmd_op)
              OpInc: begin
                pc_q   <= pc_q + 16'd1;
                done_q <= 1'b1;
              end
              OpBranch: begin
                pc_q[7:0] <= target[7:0];
                if (target[15:8] == pc_q[15:8]) begin
                  done_q <= 1'b1;
                end else begin
                  tgt_hi_q <= target[15:8];
                  state_q  <= StFix;
                end
              end
              OpJmp, OpVecRst, OpVecIrq: begin
                bus_rd_q <= 1'b1;
                state_q  <= StRdLo;
                unique case (bus.cmd_op)
                  OpJmp:    bus_addr_q <= pc_q;
                  OpVecRst: bus_addr_q <= 16'hFFFC;
                  default:  bus_addr_q <= 16'hFFFE;
                endcase
              end
              default: done_q <= 1'b1;
            endcase
          end
        end
        StFix: begin
          pc_q[15:8] <= tgt_hi_q;
          done_q     <= 1'b1;
          state_q    <= StIdle;
        end
        StRdLo: begin
          bus_addr_q <= bus_addr_q + 16'd1;
          state_q    <= StRdHi;
        end
        StRdHi: begin
          lo_q     <= bus.bus_data;
          bus_rd_q <= 1'b0;
          state_q  <= StWaitHi;
        end
        StWaitHi: begin
          pc_q    <= {bus.bus_data, lo_q};
          done_q  <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_seq.sv
// Directed checks of pc_seq against hand-computed PC, bus and handshake values.
module tb_pc_seq;

  localparam logic [15:0] RstPc = 16'hFFFE;

  logic        clk;
  logic        rst;
  logic        nmi;
  logic [15:0] pc;
  logic        done;
  logic [7:0]  mem [0:65535];

  int n_vec = 0;
  int n_err = 0;

  pc_seq_if bif ();

  pc_seq #(.RST_PC(RstPc)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bif.slave),
    .nmi  (nmi),
    .pc   (pc),
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte memory answers one cycle after the read strobe.
  always @(posedge clk) begin
    if (bif.bus_rd) bif.bus_data <= mem[bif.bus_addr];
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Presents a command for one edge; returns at the first negedge after the accept edge.
  task automatic send(input logic [2:0] op, input logic [7:0] off);
    @(negedge clk);
    bif.cmd_valid = 1'b1;
    bif.cmd_op    = op;
    bif.cmd_off   = off;
    @(negedge clk);
    bif.cmd_valid = 1'b0;
  endtask

  // Latency counted in edges since the accept edge; bounded.
  task automatic wait_done(input string tag, input int exp_lat);
    int lat = 1;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check(tag, lat, exp_lat);
  endtask

  task automatic load_pc(input logic [15:0] val);
    mem[16'hFFFC] = val[7:0];
    mem[16'hFFFD] = val[15:8];
    send(3'd3, 8'h00);
    wait_done("load_lat", 4);
    check("load_pc", pc, val);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    rst           = 1'b1;
    nmi           = 1'b0;
    bif.cmd_valid = 1'b0;
    bif.cmd_op    = 3'd0;
    bif.cmd_off   = 8'h00;
    bif.bus_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_pc", pc, RstPc);
    check("rst_bus_rd", bif.bus_rd, 0);
    check("rst_bus_addr", bif.bus_addr, 0);
    check("rst_done", done, 0);
    check("rst_ready", bif.cmd_ready, 0);
    rst = 1'b0;

    // Back-to-back INC with wrap.
    send(3'd0, 8'h00);
    check("inc1_pc", pc, 16'hFFFF);
    check("inc1_done", done, 1);
    check("inc1_ready", bif.cmd_ready, 1);
    send(3'd0, 8'h00);
    check("inc2_pc", pc, 16'h0000);
    check("inc2_done", done, 1);
    send(3'd0, 8'h00);
    check("inc3_pc", pc, 16'h0001);
    check("inc3_done", done, 1);
    check("inc3_ready", bif.cmd_ready, 1);

    // Reserved op leaves pc alone.
    send(3'd6, 8'h55);
    check("rsv_pc", pc, 16'h0001);
    check("rsv_done", done, 1);

    // Page-crossing branch shows the stale high byte for one cycle.
    load_pc(16'h10F0);
    send(3'd1, 8'h20);
    check("bx_mid_pc", pc, 16'h1010);
    check("bx_mid_done", done, 0);
    @(negedge clk);
    check("bx_pc", pc, 16'h1110);
    check("bx_done", done, 1);

    // Backward branch within the page.
    load_pc(16'h1080);
    send(3'd1, 8'hF0);
    check("bn_pc", pc, 16'h1070);
    check("bn_done", done, 1);

    // JMP from FFFF: operand high byte wraps to 0000.
    load_pc(16'hFFFF);
    mem[16'hFFFF] = 8'h34;
    mem[16'h0000] = 8'h12;
    send(3'd2, 8'h00);
    check("jmp_rd1", bif.bus_rd, 1);
    check("jmp_addr1", bif.bus_addr, 16'hFFFF);
    check("jmp_pc1", pc, 16'hFFFF);
    @(negedge clk);
    check("jmp_rd2", bif.bus_rd, 1);
    check("jmp_addr2", bif.bus_addr, 16'h0000);
    @(negedge clk);
    check("jmp_rd3", bif.bus_rd, 0);
    check("jmp_pc3", pc, 16'hFFFF);
    check("jmp_done3", done, 0);
    @(negedge clk);
    check("jmp_pc", pc, 16'h1234);
    check("jmp_done", done, 1);
    @(negedge clk);
    check("jmp_done_once", done, 0);

    // Vectors.
    mem[16'hFFFC] = 8'h00;
    mem[16'hFFFD] = 8'hC0;
    send(3'd3, 8'h00);
    wait_done("vrst_lat", 4);
    check("vrst_pc", pc, 16'hC000);
    mem[16'hFFFE] = 8'h34;
    mem[16'hFFFF] = 8'h12;
    send(3'd4, 8'h00);
    wait_done("virq_lat", 4);
    check("virq_pc", pc, 16'h1234);

    // NMI edge during RD_HI of a JMP, with cmd_valid held high.
    mem[16'h1234] = 8'h78;
    mem[16'h1235] = 8'h56;
    mem[16'hFFFA] = 8'hAA;
    mem[16'hFFFB] = 8'hBB;
    @(negedge clk);
    bif.cmd_valid = 1'b1;
    bif.cmd_op    = 3'd2;
    @(negedge clk);
    check("nj_rd_lo", bif.bus_addr, 16'h1234);
    @(negedge clk);
    check("nj_rd_hi", bif.bus_addr, 16'h1235);
    nmi = 1'b1;
    @(negedge clk);
    check("nj_wait_ready", bif.cmd_ready, 0);
    @(negedge clk);
    check("nj_pc", pc, 16'h5678);
    check("nj_done", done, 1);
    check("nj_ready", bif.cmd_ready, 0);
    @(negedge clk);
    bif.cmd_valid = 1'b0;
    check("nmi_rd", bif.bus_rd, 1);
    check("nmi_addr", bif.bus_addr, 16'hFFFA);
    check("nmi_ready", bif.cmd_ready, 0);
    @(negedge clk);
    check("nmi_addr2", bif.bus_addr, 16'hFFFB);
    @(negedge clk);
    @(negedge clk);
    check("nmi_pc", pc, 16'hBBAA);
    check("nmi_done", done, 1);
    repeat (4) begin
      @(negedge clk);
      check("nmi_no_retrig_rd", bif.bus_rd, 0);
      check("nmi_no_retrig_rdy", bif.cmd_ready, 1);
    end
    check("nmi_hold_pc", pc, 16'hBBAA);
    nmi = 1'b0;

    // Reset during WAIT_HI aborts without a done pulse.
    send(3'd2, 8'h00);
    @(negedge clk);
    @(negedge clk);
    check("ra_wait_rd", bif.bus_rd, 0);
    rst = 1'b1;
    @(negedge clk);
    check("ra_pc", pc, RstPc);
    check("ra_rd", bif.bus_rd, 0);
    check("ra_done", done, 0);
    rst = 1'b0;
    @(negedge clk);
    check("ra_done2", done, 0);
    check("ra_ready", bif.cmd_ready, 1);
    check("ra_pc2", pc, RstPc);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
